// File: rtl/gf2_pkg.sv
// Shared definitions for the GF(2) polynomial divider: default widths, FSM states
// and the divisor leading-term priority encoder.
package gf2_pkg;

  localparam int DW = 8;
  localparam int NW = 2 * DW - 1;
  localparam int KW = $clog2(DW);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } state_t;

  typedef struct packed {
    logic [KW-1:0] k;
    logic          zero;
  } msb_t;

  // Highest set bit of d; the last hit in an ascending scan wins.
  function automatic msb_t msb_index(input logic [DW-1:0] d);
    msb_t res;
    res.k    = '0;
    res.zero = 1'b1;
    for (int i = 0; i < DW; i++) begin
      if (d[i]) begin
        res.k    = KW'(i);
        res.zero = 1'b0;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/gf2_div_step.sv
// One long-division step over GF(2): shift the next dividend bit into the partial
// remainder, and subtract (XOR) the divisor when the leading term lands on x^k.
module gf2_div_step
  import gf2_pkg::*;
#(
  parameter int W  = DW,
  parameter int KB = KW
) (
  input  logic [W-1:0]  r,
  input  logic          b,
  input  logic [W-1:0]  d,
  input  logic [KB-1:0] k,
  output logic [W-1:0]  r_next,
  output logic          qb
);

  logic [W-1:0] t;

  // NOTE: each output gets a value on every path through the block, so no latch is inferred.
  always_comb begin
    t      = {r[W-2:0], b};
    qb     = t[k];
    r_next = qb ? (t ^ d) : t;
  end

endmodule

// File: rtl/gf2_poly_divider_seq.sv
// Sequential GF(2) polynomial long divider: n = clmul(q,d) ^ r with deg(r) < deg(d),
// one quotient bit per cycle, MSB first, behind valid/ready handshakes.
module gf2_poly_divider_seq #(
  parameter int DW = 8,
  parameter int NW = 2 * DW - 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [NW-1:0] in_n,
  input  logic [DW-1:0] in_d,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [NW-1:0] out_q,
  output logic [DW-1:0] out_r,
  output logic          out_dz
);

  import gf2_pkg::*;

  localparam int KBW = $clog2(DW);
  localparam int CW  = $clog2(NW);

  state_t          state;
  logic [NW-1:0]   n_reg;
  logic [DW-1:0]   d_reg;
  logic [KBW-1:0]  k_reg;
  logic [CW-1:0]   cnt;
  logic [DW-1:0]   r_next;
  logic            qb;
  msb_t            msb;

  assign msb = msb_index(d_reg);

  gf2_div_step #(
    .W  (DW),
    .KB (KBW)
  ) u_step (
    .r      (out_r),
    .b      (n_reg[cnt]),
    .d      (d_reg),
    .k      (k_reg),
    .r_next (r_next),
    .qb     (qb)
  );

  // NOTE: state registers use non-blocking assignments so every register sees
  // pre-edge values; the operand registers are reset too, which keeps a mid-run
  // abort fully deterministic.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_q     <= '0;
      out_r     <= '0;
      out_dz    <= 1'b0;
      n_reg     <= '0;
      d_reg     <= '0;
      k_reg     <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            n_reg    <= in_n;
            d_reg    <= in_d;
            out_q    <= '0;
            out_r    <= '0;
            out_dz   <= 1'b0;
            in_ready <= 1'b0;
            state    <= LOAD;
          end
        end
        LOAD: begin
          if (msb.zero) begin
            out_dz <= 1'b1;
            state  <= DONE;
          end else begin
            k_reg <= msb.k;
            cnt   <= CW'(NW - 1);
            state <= RUN;
          end
        end
        RUN: begin
          out_q <= {out_q[NW-2:0], qb};
          out_r <= r_next;
          if (cnt == '0) state <= DONE;
          else           cnt   <= cnt - 1'b1;
        end
        DONE: begin
          // out_valid rises one cycle after entering DONE and drops on the handshake edge.
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end else begin
            out_valid <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gf2_poly_divider_seq.sv
// Self-checking bench for gf2_poly_divider_seq: directed vector table, backpressure
// and mid-run reset sequences, then random clmul-built dividends.
`timescale 1ns/1ps
module tb_gf2_poly_divider_seq;

  localparam int DW = 8;
  localparam int NW = 15;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [NW-1:0] in_n;
  logic [DW-1:0] in_d;
  logic          out_valid;
  logic          out_ready;
  logic [NW-1:0] out_q;
  logic [DW-1:0] out_r;
  logic          out_dz;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [NW-1:0] n;
    logic [DW-1:0] d;
    logic [NW-1:0] q;
    logic [DW-1:0] r;
    logic          dz;
    int            lat;
  } vec_t;

  typedef struct {
    logic [NW-1:0] q;
    logic [DW-1:0] r;
    logic          dz;
  } exp_t;

  exp_t sb[$];

  gf2_poly_divider_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_n      (in_n),
    .in_d      (in_d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_q     (out_q),
    .out_r     (out_r),
    .out_dz    (out_dz)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] mul4(input logic [3:0] a, input logic [3:0] b);
    logic [6:0] p = '0;
    for (int i = 0; i < 4; i++) if (b[i]) p ^= 7'(a) << i;
    return p;
  endfunction

  // One-level Karatsuba (OKA) 8x8 carry-less product.
  function automatic logic [14:0] oka8(input logic [7:0] a, input logic [7:0] b);
    logic [6:0] lo, hi, mid;
    lo  = mul4(a[3:0], b[3:0]);
    hi  = mul4(a[7:4], b[7:4]);
    mid = mul4(a[3:0] ^ a[7:4], b[3:0] ^ b[7:4]) ^ lo ^ hi;
    return (15'(hi) << 8) ^ (15'(mid) << 4) ^ 15'(lo);
  endfunction

  function automatic logic [22:0] clmul_wide(input logic [NW-1:0] a, input logic [DW-1:0] b);
    logic [22:0] p = '0;
    for (int i = 0; i < DW; i++) if (b[i]) p ^= 23'(a) << i;
    return p;
  endfunction

  task automatic wait_ready();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    check("in_ready_timeout", 32'(in_ready), 32'd1);
  endtask

  task automatic accept(input logic [NW-1:0] n, input logic [DW-1:0] d);
    wait_ready();
    in_n     = n;
    in_d     = d;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_n     = ~n;
    in_d     = ~d;
  endtask

  task automatic await_result(output int seen);
    seen = 0;
    while (!out_valid && seen < 40) begin
      @(posedge clk);
      #1;
      seen++;
    end
  endtask

  task automatic compare_pop(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_q"},     32'(out_q),     32'(e.q));
      check({tag, "_r"},     32'(out_r),     32'(e.r));
      check({tag, "_dz"},    32'(out_dz),    32'(e.dz));
    end
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    check({tag, "_ready_back"}, 32'(in_ready),  32'd1);
  endtask

  task automatic do_op(input logic [NW-1:0] n, input logic [DW-1:0] d,
                       input logic [NW-1:0] q, input logic [DW-1:0] r,
                       input logic dz, input int lat, input string tag);
    int seen;
    sb.push_back('{q: q, r: r, dz: dz});
    accept(n, d);
    await_result(seen);
    check({tag, "_latency"}, 32'(seen), 32'(lat));
    compare_pop(tag);
    handshake(tag);
  endtask

  vec_t vecs[8];

  initial begin
    int seen;
    logic [7:0]    a, b, r0;
    logic [NW-1:0] n;
    int            k;

    vecs[0] = '{n: 15'h0005, d: 8'h03, q: 15'h0003, r: 8'h00, dz: 1'b0, lat: 17};
    vecs[1] = '{n: 15'h4000, d: 8'h80, q: 15'h0080, r: 8'h00, dz: 1'b0, lat: 17};
    vecs[2] = '{n: 15'h0007, d: 8'h0B, q: 15'h0000, r: 8'h07, dz: 1'b0, lat: 17};
    vecs[3] = '{n: 15'h5A5A, d: 8'h01, q: 15'h5A5A, r: 8'h00, dz: 1'b0, lat: 17};
    vecs[4] = '{n: 15'h1234, d: 8'h00, q: 15'h0000, r: 8'h00, dz: 1'b1, lat: 2};
    vecs[5] = '{n: 15'h7FFF, d: 8'h00, q: 15'h0000, r: 8'h00, dz: 1'b1, lat: 2};
    vecs[6] = '{n: 15'h0007, d: 8'h07, q: 15'h0001, r: 8'h00, dz: 1'b0, lat: 17};
    vecs[7] = '{n: 15'h0003, d: 8'h07, q: 15'h0000, r: 8'h03, dz: 1'b0, lat: 17};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_n      = '0;
    in_d      = '0;
    out_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready",  32'(in_ready),  32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_q",     32'(out_q),     32'd0);
    check("rst_out_r",     32'(out_r),     32'd0);
    check("rst_out_dz",    32'(out_dz),    32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 8; i++)
      do_op(vecs[i].n, vecs[i].d, vecs[i].q, vecs[i].r, vecs[i].dz, vecs[i].lat,
            $sformatf("vec%0d", i));

    // Backpressure: result must hold while out_ready is low and new offers are ignored.
    sb.push_back('{q: 15'h0003, r: 8'h00, dz: 1'b0});
    accept(15'h0005, 8'h03);
    await_result(seen);
    check("bp_latency", 32'(seen), 32'd17);
    for (int c = 0; c < 5; c++) begin
      if (c == 1) begin
        in_n     = 15'h4000;
        in_d     = 8'h80;
        in_valid = 1'b1;
      end
      if (c == 3) in_valid = 1'b0;
      @(posedge clk);
      #1;
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_ready", 32'(in_ready),  32'd0);
      check("bp_hold_q",     32'(out_q),     32'h0003);
      check("bp_hold_r",     32'(out_r),     32'h00);
    end
    compare_pop("bp");
    handshake("bp");
    check("bp_q_persist", 32'(out_q), 32'h0003);
    do_op(15'h0007, 8'h0B, 15'h0000, 8'h07, 1'b0, 17, "bp_next");

    // Reset in the middle of RUN aborts without emitting a result.
    accept(15'h5A5A, 8'h03);
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready",  32'(in_ready),  32'd0);
    check("mid_rst_out_q",     32'(out_q),     32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_ready_back", 32'(in_ready),  32'd1);
    check("mid_rst_no_result",  32'(out_valid), 32'd0);
    do_op(15'h4000, 8'h80, 15'h0080, 8'h00, 1'b0, 17, "after_rst");

    // Random: n = clmul(a,b) ^ r0 with deg(r0) < deg(b).
    for (int it = 0; it < 1500; it++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(1, 255));
      k = 0;
      for (int i = 0; i < DW; i++) if (b[i]) k = i;
      r0 = 8'($urandom) & 8'((1 << k) - 1);
      n  = oka8(a, b) ^ 15'(r0);
      do_op(n, b, 15'(a), r0, 1'b0, 17, "rnd");
      check("rnd_identity", 32'(clmul_wide(out_q, b) ^ 23'(out_r)), 32'(n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
